lsu_mem_master: RTL and testbench

//  Load/store initiator between the core datapath and the word-wide data memory (256x32, comb read, sync write).

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_lane_align.sv | 43 ++++
 rtl/lsu_mem_master.sv | 160 ++++++++++++++++
 tb/tb_lsu_mem_master.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states, access sizes.
// decode_size folds unlisted funct3 codes onto word accesses.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    // Stores only know B/H/W; BU/HU are meaningful for loads only.
    function automatic lsu_size_e decode_size(input logic store, input logic [2:0] f3);
        lsu_size_e sz;
        sz = SZ_W;
        if (f3 == F3_B || (!store && f3 == F3_BU)) begin
            sz = SZ_B;
        end else if (f3 == F3_H || (!store && f3 == F3_HU)) begin
            sz = SZ_H;
        end
        return sz;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: load extract with sign/zero extension, and
// sub-word store merge into the previously read word.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  lsu_size_e        size_i,
    input  logic             unsigned_i,
    input  logic [1:0]       byte_off_i,
    input  logic [XLEN-1:0]  rd_word_i,
    input  logic [XLEN-1:0]  old_word_i,
    input  logic [XLEN-1:0]  wdata_i,
    output logic [XLEN-1:0]  load_data_o,
    output logic [XLEN-1:0]  merged_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte     = rd_word_i[{byte_off_i, 3'b000} +: 8];
        ld_half     = rd_word_i[{byte_off_i[1], 4'b0000} +: 16];
        load_data_o = rd_word_i;
        case (size_i)
            SZ_B: load_data_o = unsigned_i ? {{(XLEN-8){1'b0}}, ld_byte}
                                           : {{(XLEN-8){ld_byte[7]}}, ld_byte};
            SZ_H: load_data_o = unsigned_i ? {{(XLEN-16){1'b0}}, ld_half}
                                           : {{(XLEN-16){ld_half[15]}}, ld_half};
            default: load_data_o = rd_word_i;
        endcase
    end

    always_comb begin
        merged_o = old_word_i;
        case (size_i)
            SZ_B:    merged_o[{byte_off_i, 3'b000} +: 8]     = wdata_i[7:0];
            SZ_H:    merged_o[{byte_off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: merged_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator to a word-wide comb-read/sync-write memory; sub-word stores use read-modify-write.
// Build option LSU_MISALIGN_TRAP_EN: misaligned half/word accesses complete at once with resp_err instead of aligning down.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int WORD_ADDR_W = 8,
    parameter int XLEN        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_store,
    input  logic [2:0]       req_funct3,
    input  logic [XLEN-1:0]  req_addr,
    input  logic [XLEN-1:0]  req_wdata,
    output logic             resp_valid,
    output logic [XLEN-1:0]  resp_rdata,
    output logic             resp_err,
    output logic [XLEN-1:0]  mem_A,
    output logic [XLEN-1:0]  mem_WD,
    input  logic [XLEN-1:0]  mem_RD,
    output logic             mem_writeEn
);

    localparam int AW = WORD_ADDR_W + 2;

    lsu_state_e       state_q, state_d;
    logic             store_q, store_d;
    lsu_size_e        size_q, size_d;
    logic             uns_q, uns_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic [XLEN-1:0]  word_q, word_d;
    logic [XLEN-1:0]  rdata_q, rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
    logic             err_q, err_d;
    logic             req_misal;
`endif

    lsu_size_e        req_size;
    logic [AW-1:0]    req_addr_al;
    logic [XLEN-1:0]  load_data;
    logic [XLEN-1:0]  merged;
    logic             unused_addr_hi;

    // Bits above the word index only alias, so they are never latched.
    assign unused_addr_hi = ^req_addr[XLEN-1:AW];

    always_comb begin
        req_size    = decode_size(req_store, req_funct3);
        req_addr_al = req_addr[AW-1:0];
        if (req_size == SZ_H) req_addr_al[0]   = 1'b0;
        if (req_size == SZ_W) req_addr_al[1:0] = 2'b00;
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_misal = (req_size == SZ_H && req_addr[0]) ||
                       (req_size == SZ_W && req_addr[1:0] != 2'b00);
`endif

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .size_i      (size_q),
        .unsigned_i  (uns_q),
        .byte_off_i  (addr_q[1:0]),
        .rd_word_i   (mem_RD),
        .old_word_i  (word_q),
        .wdata_i     (wdata_q),
        .load_data_o (load_data),
        .merged_o    (merged)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            store_q <= 1'b0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        store_d   = store_q;
        size_d    = size_q;
        uns_d     = uns_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        word_d    = word_q;
        rdata_d   = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
        err_d     = err_q;
`endif
        req_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    store_d = req_store;
                    size_d  = req_size;
                    uns_d   = !req_store && req_funct3[2];
                    addr_d  = req_addr_al;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    // Full-word stores need no read; everything else reads first.
                    state_d = (req_store && req_size == SZ_W) ? ST_WR : ST_RD;
`ifdef LSU_MISALIGN_TRAP_EN
                    err_d   = 1'b0;
                    if (req_misal) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
`endif
                end
            end
            ST_RD: begin
                word_d = mem_RD;
                if (store_q) begin
                    state_d = ST_WR;
                end else begin
                    rdata_d = load_data;
                    state_d = ST_RESP;
                end
            end
            ST_WR:   state_d = ST_RESP;
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_A       = {{(XLEN-WORD_ADDR_W){1'b0}}, addr_q[AW-1:2]};
    assign mem_WD      = merged;
    assign mem_writeEn = (state_q == ST_WR) & rst;
    assign resp_valid  = (state_q == ST_RESP);
    assign resp_rdata  = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign resp_err    = err_q;
`else
    assign resp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: behavioural 256x32 memory, expected responses queued per request.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic [31:0] mem_RD;
    logic        mem_writeEn;

    logic [31:0] mem [256];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_idx = '0;
    logic [31:0] bd_dat = '0;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          writes;
        string       name;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    lsu_mem_master #(.WORD_ADDR_W(8), .XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_store   (req_store),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_A       (mem_A),
        .mem_WD      (mem_WD),
        .mem_RD      (mem_RD),
        .mem_writeEn (mem_writeEn)
    );

    assign mem_RD = mem[mem_A[7:0]];

    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_dat;
        else if (mem_writeEn) mem[mem_A[7:0]] <= mem_WD;
    end

    task automatic poke(input int idx, input logic [31:0] dat);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = idx[7:0]; bd_dat = dat;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
        logic [31:0] sh;
        sh = w >> (off * 8);
        case (f3)
            3'b000: return 32'($signed(sh[7:0]));
            3'b100: return {24'h0, sh[7:0]};
            3'b001: return 32'($signed(sh[15:0]));
            3'b101: return {16'h0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] er, input logic ee,
                          input int el, input int ew, input string nm);
        exp_t e, got_e;
        int   lat, wr;
        logic got;
        logic [31:0] rd;
        logic rerr;
        e.rdata = er; e.err = ee; e.lat = el; e.writes = ew; e.name = nm;
        sb_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s ready: got %b want 1", nm, req_ready);
        end
        @(posedge clk);
        #1;
        // Junk on the request bus must be ignored once the handshake is done.
        req_valid = 1'b0; req_store = ~st; req_funct3 = $urandom_range(7, 0);
        req_addr = $urandom; req_wdata = $urandom;
        got = 1'b0; lat = 0; wr = 0; rd = '0; rerr = 1'b0;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge clk);
            if (mem_writeEn === 1'b1) wr++;
            if (resp_valid === 1'b1) begin
                got = 1'b1; lat = k; rd = resp_rdata; rerr = resp_err;
            end
        end
        got_e = sb_q.pop_front();
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL %s timeout: no resp_valid within 8 cycles", got_e.name);
        end else begin
            if (lat != got_e.lat) begin
                miscompares++;
                $display("FAIL %s latency: got %0d want %0d", got_e.name, lat, got_e.lat);
            end
            vectors++;
            if (rd !== got_e.rdata) begin
                miscompares++;
                $display("FAIL %s rdata: got %h want %h", got_e.name, rd, got_e.rdata);
            end
            vectors++;
            if (rerr !== got_e.err) begin
                miscompares++;
                $display("FAIL %s err: got %b want %b", got_e.name, rerr, got_e.err);
            end
        end
        vectors++;
        if (wr != got_e.writes) begin
            miscompares++;
            $display("FAIL %s writes: got %0d want %0d", got_e.name, wr, got_e.writes);
        end
        @(negedge clk);
        vectors++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s pulse: got valid %b ready %b want 0 1", got_e.name, resp_valid, req_ready);
        end
    endtask

    task automatic check_mem(input int idx, input logic [31:0] want, input string nm);
        vectors++;
        if (mem[idx] !== want) begin
            miscompares++;
            $display("FAIL %s mem[%0d]: got %h want %h", nm, idx, mem[idx], want);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 ||
            resp_err !== 1'b0 || mem_writeEn !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: got rdy %b vld %b rdata %h err %b we %b want 1 0 0 0 0",
                     req_ready, resp_valid, resp_rdata, resp_err, mem_writeEn);
        end
        rst = 1'b1;
    endtask

    task automatic test_load;
        poke(1, 32'h8899AABB);
        do_req(1'b0, 3'b000, 32'h5, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0, "lb_5");
        do_req(1'b0, 3'b101, 32'h6, 32'h0, 32'h00008899, 1'b0, 2, 0, "lhu_6");
        do_req(1'b0, 3'b001, 32'h6, 32'h0, 32'hFFFF8899, 1'b0, 2, 0, "lh_6");
        do_req(1'b0, 3'b010, 32'h4, 32'h0, 32'h8899AABB, 1'b0, 2, 0, "lw_4");
        do_req(1'b0, 3'b100, 32'h7, 32'h0, 32'h00000088, 1'b0, 2, 0, "lbu_7");
        do_req(1'b0, 3'b000, 32'h4, 32'h0, 32'hFFFFFFBB, 1'b0, 2, 0, "lb_4");
        do_req(1'b0, 3'b001, 32'h4, 32'h0, 32'hFFFFAABB, 1'b0, 2, 0, "lh_4");
        do_req(1'b0, 3'b011, 32'h404, 32'h0, 32'h8899AABB, 1'b0, 2, 0, "lw_f3_011_wrap");
    endtask

    task automatic test_store;
        poke(2, 32'h11223344);
        do_req(1'b1, 3'b000, 32'hA, 32'h000000EE, 32'h0, 1'b0, 3, 1, "sb_a");
        check_mem(2, 32'h11EE3344, "sb_a");
        do_req(1'b1, 3'b001, 32'h8, 32'hCAFE5555, 32'h0, 1'b0, 3, 1, "sh_8");
        check_mem(2, 32'h11EE5555, "sh_8");
        do_req(1'b1, 3'b010, 32'h404, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, "sw_404");
        check_mem(1, 32'hDEADBEEF, "sw_404");
        check_mem(2, 32'h11EE5555, "sw_404_neighbour");
        do_req(1'b1, 3'b111, 32'h8, 32'h01234567, 32'h0, 1'b0, 2, 1, "sw_f3_111");
        check_mem(2, 32'h01234567, "sw_f3_111");
    endtask

    task automatic test_misalign;
        poke(0, 32'h01020304);
`ifdef LSU_MISALIGN_TRAP_EN
        do_req(1'b1, 3'b001, 32'h3, 32'h0000ABCD, 32'h0, 1'b1, 1, 0, "sh_3_trap");
        check_mem(0, 32'h01020304, "sh_3_trap");
        do_req(1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 1'b1, 1, 0, "lw_6_trap");
        do_req(1'b0, 3'b101, 32'h1, 32'h0, 32'h0, 1'b1, 1, 0, "lhu_1_trap");
`else
        // 0x3 aligns down to 0x2, the upper half of word 0.
        do_req(1'b1, 3'b001, 32'h3, 32'h0000ABCD, 32'h0, 1'b0, 3, 1, "sh_3_align");
        check_mem(0, 32'hABCD0304, "sh_3_align");
        do_req(1'b0, 3'b010, 32'h6, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, "lw_6_align");
        do_req(1'b0, 3'b101, 32'h1, 32'h0, 32'h00000304, 1'b0, 2, 0, "lhu_1_align");
`endif
    endtask

    task automatic test_back_to_back;
        logic [31:0] words [4];
        logic [2:0]  f3s [5];
        words[0] = 32'h80FF7F01; words[1] = 32'h00807FFE;
        words[2] = 32'hFEDCBA98; words[3] = 32'h13579BDF;
        f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b010; f3s[3] = 3'b100; f3s[4] = 3'b101;
        for (int i = 0; i < 4; i++) poke(8 + i, words[i]);
        for (int n = 0; n < 12; n++) begin
            int          wi;
            logic [2:0]  f3;
            logic [1:0]  off;
            wi  = $urandom_range(3, 0);
            f3  = f3s[$urandom_range(4, 0)];
            off = 2'($urandom_range(3, 0));
            if (f3[1:0] == 2'b01) off[0] = 1'b0;
            if (f3 == 3'b010) off = 2'b00;
            do_req(1'b0, f3, 32'h20 + wi * 4 + off, 32'h0, ref_load(words[wi], f3, off),
                   1'b0, 2, 0, "rand_load");
        end
    endtask

    task automatic test_reset_in_wr;
        poke(3, 32'hA5A5A5A5);
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'hC; req_wdata = 32'h11;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (mem_writeEn !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_wr in_wr: got writeEn %b want 1", mem_writeEn);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (mem_writeEn !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_wr suppress: got writeEn %b want 0", mem_writeEn);
        end
        @(negedge clk);
        rst = 1'b1;
        vectors++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_wr idle: got ready %b valid %b want 1 0", req_ready, resp_valid);
        end
        check_mem(3, 32'hA5A5A5A5, "rst_wr");
        do_req(1'b0, 3'b010, 32'hC, 32'h0, 32'hA5A5A5A5, 1'b0, 2, 0, "rst_wr_after");
    endtask

    initial begin
        test_reset;
        test_load;
        test_store;
        test_misalign;
        test_back_to_back;
        test_reset_in_wr;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
